dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Word-addressed data-memory model that sits on the memory side of the dmem interface and serves requests from the data cache.
- Accepts single-cycle read/write request pulses, waits a fixed wait-state latency, then commits byte-strobed writes or returns read data.
- Signals idle/completion on dmem_ready_o.
- Used as the backing store in cache and core testbenches, and as the synthesizable scratch RAM in small configurations.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data/word width; multiple of 8.
- DEPTH, 1024, number of words; power of 2, >=2.
- LATENCY, 2, wait cycles per access; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dmem_addr_i  in  ADDR_WIDTH  byte address of request.
- dmem_wdata_i  in  DATA_WIDTH  write data.
- dmem_write_i  in  1  write request pulse.
- dmem_wstrb_i  in  DATA_WIDTH/8  byte enables for write.
- dmem_read_i  in  1  read request pulse.
- dmem_rdata_o  out  DATA_WIDTH  read data, registered.
- dmem_ready_o  out  1  high = idle and able to accept; also marks completion.

Behaviour:
- Reset values: dmem_ready_o=1, dmem_rdata_o=0, state=DmemIdle, wait counter=0, pending request cleared. Memory array is not reset; contents are undefined until written.
- Addressing: word index = dmem_addr_i[$clog2(DEPTH)+1:2]. Bits [1:0] are ignored. Bits above the index alias (wrap modulo DEPTH words).
- Accept rule: a request is accepted in any cycle where state=DmemIdle and (dmem_read_i | dmem_write_i). On acceptance, latch addr, wdata, wstrb and op; load cnt=LATENCY-1; go to DmemBusy.
- Simultaneous read and write: treated as a write; the read is dropped and rdata is unchanged.
- dmem_write_i with wstrb=0: accepted, takes full latency, memory unchanged.
- DmemBusy: dmem_ready_o=0. Request inputs are ignored; the initiator must not issue while ready is low (bench assertion).
  - If cnt!=0: cnt decrements.
  - If cnt==0, at that edge: a write updates only the bytes with wstrb[i]=1; a read loads dmem_rdata_o from the array; state goes to DmemIdle.
- Timing: request accepted in cycle T. dmem_ready_o is low in T+1..T+LATENCY and high in T+LATENCY+1. For a read, rdata is valid from T+LATENCY+1.
- rdata holding: dmem_rdata_o holds its value until the next completed read. Writes do not disturb it.
- Back-to-back: a new request may be presented in the first ready-high cycle and is accepted immediately, so sustained throughput is one access per LATENCY+1 cycles.
- Read-after-write to the same word returns the new data. The write commits before the later read is accepted, so no forwarding is needed.
- Reset asserted mid-access: the pending access is aborted, a pending write is discarded, and the outputs return to their reset values asynchronously.
- State machine: DmemIdle -(req)-> DmemBusy -(cnt==0)-> DmemIdle. No other states.

Optional Feature:
- Macro DMEM_RANDOM_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) steps on every accepted request.
  - Its bits [1:0] are added to the loaded counter (cnt=LATENCY-1+lfsr[1:0]), giving 0..3 extra wait cycles.
  - The sequence is deterministic from reset.
- Undefined: the LFSR is absent and latency is exactly LATENCY. Ports are identical in both builds.

Decomposition:
- Package dmem_pkg: dmem_state_e {DmemIdle, DmemBusy}; DMEM_MAX_LATENCY=15; DMEM_LFSR_SEED=8'hA5; DMEM_LFSR_TAPS.
- Sub-module dmem_sram: DEPTH x DATA_WIDTH synchronous array with per-byte write enable and registered read port. Instantiated once.
- The LFSR stays inline inside the macro guard.

Test Plan:
- Reset then idle: dmem_ready_o=1, dmem_rdata_o=0, no state change with requests low for 10 cycles.
- Write addr 0x40, data 0xDEADBEEF, wstrb 4'hF, LATENCY=2: ready low 2 cycles, high in 3rd. Then a read of 0x40 returns 0xDEADBEEF exactly 3 cycles after acceptance.
- Partial strobe: write 0x11223344 to 0x8, then 0xAABBCCDD with wstrb 4'b0101; read 0x8 -> 0x11BB33DD.
- Alias/wrap, DEPTH=1024: write 0x5 to addr 0x0000_1004, read addr 0x0000_0004 -> 0x5. Read and write asserted together -> treated as a write, rdata unchanged.
- Reset mid-write: accept write 0x7 to 0x10 over old value 0x3, drop rst_n during BUSY -> ready=1 immediately; read 0x10 -> 0x3.
- With DMEM_RANDOM_STALL_EN: 16 back-to-back reads -> each ready-low span in 2..5 cycles, matching a reference LFSR model seeded 8'hA5.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem responder and its storage array.
package dmem_pkg;

    // Two-state access sequencer: waiting for a request, or counting wait states.
    typedef enum logic {
        DmemIdle = 1'b0,
        DmemBusy = 1'b1
    } dmem_state_e;

    // Largest legal wait-state latency.
    localparam int DMEM_MAX_LATENCY = 15;

    // Random-stall LFSR: seed after reset and tap mask for taps 8,6,5,4.
    localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;
    localparam logic [7:0] DMEM_LFSR_TAPS = 8'b1011_1000;

    // Counter must hold LATENCY-1 plus up to 3 extra stall cycles.
    localparam int DMEM_CNT_W = $clog2(DMEM_MAX_LATENCY + 4);

    // One Fibonacci step: shift left, feed back the XOR of the tapped bits.
    function automatic logic [7:0] dmem_lfsr_step(input logic [7:0] state);
        return {state[6:0], ^(state & DMEM_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x DATA_WIDTH synchronous array with per-byte write enables and a
// registered read port. The array itself is never reset; only the read
// register returns to zero on reset.
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IDX_W-1:0]        addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-granular write; only lanes with their strobe set are updated.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Read register loads only on a read enable, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the dmem interface. Requests are
// accepted while idle, held for a fixed number of wait states, then committed
// (write) or returned on dmem_rdata_o (read).
// Optional build macro DMEM_RANDOM_STALL_EN adds 0..3 pseudo-random extra
// wait cycles per access from an 8-bit LFSR seeded on reset.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic                    dmem_write_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    input  logic                    dmem_read_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_WIDTH / 8;

    dmem_state_e             state_q, state_d;
    logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           wstrb_q, wstrb_d;
    logic                    op_write_q, op_write_d;

    logic                    req_accept;
    logic                    mem_we;
    logic                    mem_re;
    logic [DMEM_CNT_W-1:0]   stall_extra;

    // Byte-offset bits and bits above the word index do not select storage;
    // the upper bits simply alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr_i[1:0], dmem_addr_i[ADDR_WIDTH-1:IDX_W+2]};

    assign req_accept = (state_q == DmemIdle) && (dmem_read_i || dmem_write_i);

`ifdef DMEM_RANDOM_STALL_EN
    logic [7:0] lfsr_q;

    // LFSR advances once per accepted request; the pre-step value sets this access's stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= DMEM_LFSR_SEED;
        end else if (req_accept) begin
            lfsr_q <= dmem_lfsr_step(lfsr_q);
        end
    end

    assign stall_extra = DMEM_CNT_W'(lfsr_q[1:0]);
`else
    assign stall_extra = '0;
`endif

    // State, wait counter and latched request; cleared on reset so a pending access is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DmemIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            op_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            op_write_q <= op_write_d;
        end
    end

    // Next-state logic: accept while idle, count down while busy, commit at zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        op_write_d = op_write_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        case (state_q)
            DmemIdle: begin
                if (req_accept) begin
                    idx_d      = dmem_addr_i[IDX_W+1:2];
                    wdata_d    = dmem_wdata_i;
                    wstrb_d    = dmem_wstrb_i;
                    // A write alongside a read wins; the read is discarded.
                    op_write_d = dmem_write_i;
                    cnt_d      = DMEM_CNT_W'(LATENCY - 1) + stall_extra;
                    state_d    = DmemBusy;
                end
            end
            DmemBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_we  = op_write_q;
                    mem_re  = !op_write_q;
                    state_d = DmemIdle;
                end
            end
            default: begin
                state_d = DmemIdle;
            end
        endcase
    end

    assign dmem_ready_o = (state_q == DmemIdle);

    dmem_sram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (idx_q),
        .we_i    (mem_we),
        .wstrb_i (wstrb_q),
        .wdata_i (wdata_q),
        .re_i    (mem_re),
        .rdata_o (dmem_rdata_o)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (default parameters, LATENCY=2).
// When DMEM_RANDOM_STALL_EN is defined the expected wait span per access
// follows a reference LFSR seeded with 8'hA5.
module tb_dmem_responder;

    localparam int LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic        dmem_write_i;
    logic [3:0]  dmem_wstrb_i;
    logic        dmem_read_i;
    logic [31:0] dmem_rdata_o;
    logic        dmem_ready_o;

    int          n_checks;
    int          n_fail;
    logic [7:0]  lfsr_model;
    logic [31:0] rd;

    dmem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (1024),
        .LATENCY    (LATENCY)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_write_i (dmem_write_i),
        .dmem_wstrb_i (dmem_wstrb_i),
        .dmem_read_i  (dmem_read_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_ready_o (dmem_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected wait span for the next accepted request; advances the model.
    function automatic int next_span();
        int s;
        s = LATENCY;
`ifdef DMEM_RANDOM_STALL_EN
        s = s + int'(lfsr_model[1:0]);
        lfsr_model = {lfsr_model[6:0], lfsr_model[7] ^ lfsr_model[5] ^ lfsr_model[4] ^ lfsr_model[3]};
`endif
        return s;
    endfunction

    // One access starting just after a rising edge; returns rdata seen in the first ready-high cycle.
    task automatic do_access(input string name, input bit r, input bit w, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, output logic [31:0] rdata);
        int span;
        int exp_span;
        check({name, "_ready_before"}, {31'd0, dmem_ready_o}, 32'd1);
        exp_span     = next_span();
        dmem_addr_i  = addr;
        dmem_wdata_i = data;
        dmem_wstrb_i = strb;
        dmem_read_i  = r;
        dmem_write_i = w;
        @(posedge clk);
        #1;
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
        span = 0;
        while (dmem_ready_o !== 1'b1 && span < 64) begin
            span++;
            @(posedge clk);
            #1;
        end
        check({name, "_span"}, span, exp_span);
        rdata = dmem_rdata_o;
        $display("txn %-10s rd=%0d wr=%0d addr=0x%08h wdata=0x%08h strb=%b span=%0d rdata=0x%08h",
                 name, r, w, addr, data, strb, span, rdata);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        lfsr_model   = 8'hA5;
        rst_n        = 1'b0;
        dmem_addr_i  = '0;
        dmem_wdata_i = '0;
        dmem_write_i = 1'b0;
        dmem_wstrb_i = '0;
        dmem_read_i  = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, dmem_ready_o}, 32'd1);
        check("rst_rdata", dmem_rdata_o, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_ready", {31'd0, dmem_ready_o}, 32'd1);
        check("idle_rdata", dmem_rdata_o, 32'h0);

        // Full write then read-back
        do_access("wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd);
        check("wr40_rdata_hold", rd, 32'h0);
        do_access("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd);
        check("rd40_data", rd, 32'hDEADBEEF);

        // Partial strobe merge
        do_access("wr8_full", 1'b0, 1'b1, 32'h8, 32'h11223344, 4'hF, rd);
        do_access("wr8_part", 1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd);
        check("wr8_rdata_hold", rd, 32'hDEADBEEF);
        do_access("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd);
        check("rd8_data", rd, 32'h11BB33DD);

        // Zero strobe write leaves memory alone
        do_access("wr40_z", 1'b0, 1'b1, 32'h40, 32'h12345678, 4'h0, rd);
        do_access("rd40_z", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd);
        check("rd40_z_data", rd, 32'hDEADBEEF);

        // Address aliasing above the index bits, byte offset ignored
        do_access("wr1004", 1'b0, 1'b1, 32'h0000_1004, 32'h5, 4'hF, rd);
        do_access("rd4", 1'b1, 1'b0, 32'h0000_0006, 32'h0, 4'h0, rd);
        check("rd4_alias", rd, 32'h5);

        // Read and write together behave as a write
        do_access("rdwr4", 1'b1, 1'b1, 32'h4, 32'h99, 4'hF, rd);
        check("rdwr4_rdata", rd, 32'h5);
        do_access("rd4b", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd);
        check("rd4b_data", rd, 32'h99);

        // Reset in the middle of a write aborts it
        do_access("wr10", 1'b0, 1'b1, 32'h10, 32'h3, 4'hF, rd);
        check("abort_ready_before", {31'd0, dmem_ready_o}, 32'd1);
        dmem_addr_i  = 32'h10;
        dmem_wdata_i = 32'h7;
        dmem_wstrb_i = 4'hF;
        dmem_write_i = 1'b1;
        @(posedge clk);
        #1;
        dmem_write_i = 1'b0;
        check("abort_busy", {31'd0, dmem_ready_o}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, dmem_ready_o}, 32'd1);
        check("abort_rdata", dmem_rdata_o, 32'h0);
        $display("txn %-10s reset asserted during busy write of 0x7 to 0x10", "abort");
        lfsr_model = 8'hA5;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd);
        check("rd10_old", rd, 32'h3);

        // Back-to-back reads: each span follows the expected latency sequence
        for (int i = 0; i < 16; i++) begin
            do_access($sformatf("b2b%0d", i), 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd);
            check($sformatf("b2b%0d_data", i), rd, 32'hDEADBEEF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
